clock_mode_ctrl: RTL
====================

Name: clock_mode_ctrl

Overview:
- Top-level sequencer for the alarm-clock datapath.
- Drives the en/upDown inputs of the seconds (mod-60), minutes (mod-60) and hours (mod-24) time counters, and of the alarm minute/hour counters.
- Implements run, time-set and alarm-set modes from push-button edges.
- Compares live time against the alarm setting and sequences the ringing state with dismiss and timeout.

Parameters:
- RING_SECS, 60, number of 1 Hz ticks the buzzer stays on before auto-dismiss (1..255).
- TIMER_W, 8, width of the internal ring-duration tick counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-clk-wide pulse, once per second
- btn_c  in  1  debounced mode button (level)
- btn_u  in  1  debounced increment button (level)
- btn_d  in  1  debounced decrement button (level)
- alarm_sw  in  1  alarm armed switch (level)
- sec_count  in  6  current seconds counter value
- min_count  in  6  current minutes counter value
- hr_count  in  5  current hours counter value
- alm_min  in  6  alarm minutes counter value
- alm_hr  in  5  alarm hours counter value
- sec_en  out  1  seconds counter enable pulse
- min_en  out  1  minutes counter enable pulse
- hr_en  out  1  hours counter enable pulse
- amin_en  out  1  alarm-minute counter enable pulse
- ahr_en  out  1  alarm-hour counter enable pulse
- up_down  out  1  shared counter direction, 1 = up
- mode  out  3  current state encoding (LED display)
- buzzer  out  1  alarm sounding

Behaviour:
- **Reset** (rst=0, async):
  - state=RUN, all *_en=0, up_down=1, buzzer=0, fired=0, ring timer=0.
  - Button-history registers are set to 1, so a button held through reset produces no edge.
- **Edge detect:** edge_x = btn_x & ~btn_x_q, with btn_x_q registered every clk.
- **Output timing:** all outputs are registered. Each *_en pulse is exactly 1 clk wide and appears 1 clk after its cause (tick or edge).
- **States and mode encoding:** RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4, RINGING=5.
- **btn_c sequence:** RUN -> SET_HR -> SET_MIN -> ALM_HR -> ALM_MIN -> RUN, one step per edge_c.
- **RUN and RINGING enables:** on tick_1hz:
  - sec_en=1.
  - min_en=1 iff sec_count==59.
  - hr_en=1 iff sec_count==59 and min_count==59.
  - up_down=1.
  - Counter wrap is handled by the counters themselves.
- **SET/ALM states:**
  - tick_1hz is ignored, so time is frozen.
  - edge_u alone pulses the target enable with up_down=1; edge_d alone pulses it with up_down=0.
  - Targets: SET_HR->hr_en, SET_MIN->min_en, ALM_HR->ahr_en, ALM_MIN->amin_en.
  - edge_u and edge_d in the same cycle: no pulse.
  - No carry: min_en never produces hr_en in SET_MIN.
  - up_down returns to 1 on the cycle after a down pulse.
- **Alarm detect (RUN only):** match = alarm_sw & hr_count==alm_hr & min_count==alm_min & sec_count==0.
  - match & ~fired -> RINGING, fired=1, buzzer=1, ring timer=0.
  - fired clears when hr_count/min_count no longer equal the alarm values.
  - As a result, dismissing during the match second does not re-ring.
- **RINGING:**
  - Counting continues as in RUN.
  - The ring timer increments on each tick_1hz.
  - Exit to RUN with buzzer=0 when any of these occurs:
    - edge_c (dismiss only; does not also advance the mode);
    - alarm_sw=0 (next clk);
    - a tick with timer==RING_SECS-1.
- **Simultaneous events:**
  - tick and edge_c in the same cycle in RUN: the tick's enables are still issued, and the state moves to SET_HR.
  - edge_c and match in the same cycle: edge_c wins, fired=1, so there is no ring that minute.
  - tick and dismiss in RINGING: enables are issued, then RUN.
- **Alarm settings changed while fired:** editing the alarm while fired=1 clears fired once there is a mismatch, which re-enables detection.
- **Reset mid-operation** returns everything to reset values immediately. Counter values themselves are owned by the counters.

Test Plan:
- **Run counting:** RUN with sec=59, min=59, hr=23, pulse tick_1hz -> next clk sec_en=min_en=hr_en=1, up_down=1; all 0 the clk after.
- **Set hours:** three btn_c edges reach ALM_HR (mode=3); btn_u edge -> ahr_en 1-clk pulse, up_down=1; btn_d edge -> ahr_en pulse, up_down=0. Ticks in this state -> no sec_en.
- **Simultaneous u/d:** in SET_MIN, btn_u and btn_d rise in the same clk -> no min_en. Holding btn_u 100 clks -> exactly one pulse.
- **Alarm fire:** alarm_sw=1, alm=07:30, live 07:30:00 in RUN -> next clk mode=5, buzzer=1. btn_c edge -> mode=0, buzzer=0, and no re-ring while the time is 07:30:xx.
- **Timeout:** RING_SECS=3, ring with no input -> buzzer drops on the clk after the 3rd tick, mode=0, seconds keep counting throughout.
- **Async reset:** assert rst=0 mid-RINGING between clk edges -> buzzer=0, mode=0 immediately. Release with btn_c held -> no mode change.

Source files
------------

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the alarm clock: drives the time/alarm counter enables,
// walks the run/set/alarm-set modes from button edges and rings the buzzer.
module clock_mode_ctrl #(
    parameter int RING_SECS = 60,
    parameter int TIMER_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_sw,
    input  logic [5:0] sec_count,
    input  logic [5:0] min_count,
    input  logic [4:0] hr_count,
    input  logic [5:0] alm_min,
    input  logic [4:0] alm_hr,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       amin_en,
    output logic       ahr_en,
    output logic       up_down,
    output logic [2:0] mode,
    output logic       buzzer
);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        ALM_HR  = 3'd3,
        ALM_MIN = 3'd4,
        RINGING = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] RING_LAST = TIMER_W'(RING_SECS - 1);

    state_t             state, state_n;
    logic               btn_c_q, btn_u_q, btn_d_q;
    logic               fired, fired_n;
    logic [TIMER_W-1:0] ring_timer, ring_timer_n;
    logic               sec_en_n, min_en_n, hr_en_n, amin_en_n, ahr_en_n;
    logic               up_down_n, buzzer_n;
    logic               edge_c, edge_u, edge_d, step;
    logic               alarm_eq, match;

    assign edge_c   = btn_c & ~btn_c_q;
    assign edge_u   = btn_u & ~btn_u_q;
    assign edge_d   = btn_d & ~btn_d_q;
    assign step     = edge_u ^ edge_d;
    assign alarm_eq = (hr_count == alm_hr) && (min_count == alm_min);
    assign match    = alarm_sw && alarm_eq && (sec_count == 6'd0);
    assign mode     = state;

    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            btn_c_q    <= 1'b1;
            btn_u_q    <= 1'b1;
            btn_d_q    <= 1'b1;
            fired      <= 1'b0;
            ring_timer <= '0;
            sec_en     <= 1'b0;
            min_en     <= 1'b0;
            hr_en      <= 1'b0;
            amin_en    <= 1'b0;
            ahr_en     <= 1'b0;
            up_down    <= 1'b1;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_n;
            btn_c_q    <= btn_c;
            btn_u_q    <= btn_u;
            btn_d_q    <= btn_d;
            fired      <= fired_n;
            ring_timer <= ring_timer_n;
            sec_en     <= sec_en_n;
            min_en     <= min_en_n;
            hr_en      <= hr_en_n;
            amin_en    <= amin_en_n;
            ahr_en     <= ahr_en_n;
            up_down    <= up_down_n;
            buzzer     <= buzzer_n;
        end
    end

    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_n      = state;
        fired_n      = fired;
        ring_timer_n = ring_timer;
        sec_en_n     = 1'b0;
        min_en_n     = 1'b0;
        hr_en_n      = 1'b0;
        amin_en_n    = 1'b0;
        ahr_en_n     = 1'b0;
        up_down_n    = 1'b1;

        // Leaving the alarm minute re-arms detection for the next match.
        if (!alarm_eq) fired_n = 1'b0;

        if ((state == RUN || state == RINGING) && tick_1hz) begin
            sec_en_n = 1'b1;
            min_en_n = (sec_count == 6'd59);
            hr_en_n  = (sec_count == 6'd59) && (min_count == 6'd59);
        end

        case (state)
            RUN: begin
                if (edge_c) begin
                    state_n = SET_HR;
                    if (match) fired_n = 1'b1;
                end else if (match && !fired) begin
                    state_n      = RINGING;
                    fired_n      = 1'b1;
                    ring_timer_n = '0;
                end
            end
            SET_HR: begin
                if (step) begin
                    hr_en_n   = 1'b1;
                    up_down_n = edge_u;
                end
                if (edge_c) state_n = SET_MIN;
            end
            SET_MIN: begin
                if (step) begin
                    min_en_n  = 1'b1;
                    up_down_n = edge_u;
                end
                if (edge_c) state_n = ALM_HR;
            end
            ALM_HR: begin
                if (step) begin
                    ahr_en_n  = 1'b1;
                    up_down_n = edge_u;
                end
                if (edge_c) state_n = ALM_MIN;
            end
            ALM_MIN: begin
                if (step) begin
                    amin_en_n = 1'b1;
                    up_down_n = edge_u;
                end
                if (edge_c) state_n = RUN;
            end
            RINGING: begin
                if (tick_1hz) ring_timer_n = ring_timer + TIMER_W'(1);
                if (edge_c || !alarm_sw || (tick_1hz && ring_timer == RING_LAST))
                    state_n = RUN;
            end
            default: state_n = RUN;
        endcase

        buzzer_n = (state_n == RINGING);
    end

endmodule
